// File: rtl/dip_switch_debouncer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dip_switch_debouncer_pkg
// Brief    : Shared constants for the DIP-switch input-conditioning stage.
// Revision : 1.0
// ============================================================================
package dip_switch_debouncer_pkg;

    localparam logic [7:0] C_DIP_RESET_VAL           = 8'hFF;
    localparam int         C_DEFAULT_DEBOUNCE_CYCLES = 20000;
    localparam int         C_NUM_BANKS               = 8;

endpackage : dip_switch_debouncer_pkg
`default_nettype wire

// File: rtl/dip_bank_debounce.sv
`default_nettype none
// ============================================================================
// Module   : dip_bank_debounce
// Brief    : One 8-bit bank: 2-flop synchronizer plus byte-granular debounce.
// Revision : 1.0
// ============================================================================
module dip_bank_debounce
    import dip_switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] raw_i,
    output logic [7:0] stable_o,
    output logic       chg_set_o
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [7:0]       sync1_q;
    logic [7:0]       sync2_q;
    logic [7:0]       cand_q,   cand_d;
    logic [7:0]       stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             w_accept;

    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        w_accept = 1'b0;
        if (sync2_q == stable_q) begin
            cand_d = stable_q;
            cnt_d  = '0;
        end else if (sync2_q != cand_q) begin
            cand_d = sync2_q;
            cnt_d  = '0;
        end else if (cnt_q == C_CNT_MAX) begin
            stable_d = cand_q;
            cnt_d    = '0;
            w_accept = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // sync1 -> sync2 is a bare flop chain; nothing may be inserted between them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q  <= C_DIP_RESET_VAL;
            sync2_q  <= C_DIP_RESET_VAL;
            cand_q   <= C_DIP_RESET_VAL;
            stable_q <= C_DIP_RESET_VAL;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_i;
            sync2_q  <= sync1_q;
            cand_q   <= cand_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o  = stable_q;
    assign chg_set_o = w_accept;

endmodule : dip_bank_debounce
`default_nettype wire

// File: rtl/dip_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : dip_switch_debouncer
// Brief    : Eight debounced DIP banks with sticky change flags and level IRQ.
// Revision : 1.0
// ============================================================================
module dip_switch_debouncer
    import dip_switch_debouncer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = C_DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] dip_raw0,
    input  logic [7:0] dip_raw1,
    input  logic [7:0] dip_raw2,
    input  logic [7:0] dip_raw3,
    input  logic [7:0] dip_raw4,
    input  logic [7:0] dip_raw5,
    input  logic [7:0] dip_raw6,
    input  logic [7:0] dip_raw7,
    output logic [7:0] dip_switch0,
    output logic [7:0] dip_switch1,
    output logic [7:0] dip_switch2,
    output logic [7:0] dip_switch3,
    output logic [7:0] dip_switch4,
    output logic [7:0] dip_switch5,
    output logic [7:0] dip_switch6,
    output logic [7:0] dip_switch7,
    input  logic [7:0] clr_changed,
    output logic [7:0] changed,
    output logic       irq
);

    logic [7:0]             w_raw    [C_NUM_BANKS];
    logic [7:0]             w_stable [C_NUM_BANKS];
    logic [C_NUM_BANKS-1:0] w_set;
    logic [C_NUM_BANKS-1:0] changed_q, changed_d;

    assign w_raw[0] = dip_raw0;
    assign w_raw[1] = dip_raw1;
    assign w_raw[2] = dip_raw2;
    assign w_raw[3] = dip_raw3;
    assign w_raw[4] = dip_raw4;
    assign w_raw[5] = dip_raw5;
    assign w_raw[6] = dip_raw6;
    assign w_raw[7] = dip_raw7;

    generate
        for (genvar b = 0; b < C_NUM_BANKS; b++) begin : g_bank
            dip_bank_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .CNT_W           (CNT_W)
            ) u_bank (
                .clk       (clk),
                .reset     (reset),
                .raw_i     (w_raw[b]),
                .stable_o  (w_stable[b]),
                .chg_set_o (w_set[b])
            );
        end
    endgenerate

    // A set arriving in the same cycle as its clear must win.
    always_comb begin
        changed_d = (changed_q & ~clr_changed) | w_set;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            changed_q <= '0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign dip_switch0 = w_stable[0];
    assign dip_switch1 = w_stable[1];
    assign dip_switch2 = w_stable[2];
    assign dip_switch3 = w_stable[3];
    assign dip_switch4 = w_stable[4];
    assign dip_switch5 = w_stable[5];
    assign dip_switch6 = w_stable[6];
    assign dip_switch7 = w_stable[7];
    assign changed     = changed_q;
    assign irq         = |changed_q;

endmodule : dip_switch_debouncer
`default_nettype wire

// File: tb/tb_dip_switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module   : tb_dip_switch_debouncer
// Brief    : Directed self-checking bench for dip_switch_debouncer (4-cycle debounce).
// Revision : 1.0
// ============================================================================
module tb_dip_switch_debouncer;

    localparam int DEBOUNCE_CYCLES = 4;
    localparam int CNT_W           = 3;

    logic       clk;
    logic       reset;
    logic [7:0] raw [8];
    logic [7:0] sw  [8];
    logic [7:0] clr_changed;
    logic [7:0] changed;
    logic       irq;

    int vectors     = 0;
    int miscompares = 0;

    dip_switch_debouncer #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .dip_raw0    (raw[0]),
        .dip_raw1    (raw[1]),
        .dip_raw2    (raw[2]),
        .dip_raw3    (raw[3]),
        .dip_raw4    (raw[4]),
        .dip_raw5    (raw[5]),
        .dip_raw6    (raw[6]),
        .dip_raw7    (raw[7]),
        .dip_switch0 (sw[0]),
        .dip_switch1 (sw[1]),
        .dip_switch2 (sw[2]),
        .dip_switch3 (sw[3]),
        .dip_switch4 (sw[4]),
        .dip_switch5 (sw[5]),
        .dip_switch6 (sw[6]),
        .dip_switch7 (sw[7]),
        .clr_changed (clr_changed),
        .changed     (changed),
        .irq         (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic check_all_sw(input string tag, input logic [7:0] expected);
        for (int i = 0; i < 8; i++) begin
            check($sformatf("%s_sw%0d", tag, i), sw[i], expected);
        end
    endtask

    initial begin
        reset       = 1'b1;
        clr_changed = 8'h00;
        for (int i = 0; i < 8; i++) raw[i] = 8'hFF;

        // Reset state
        tick(3);
        check_all_sw("rst", 8'hFF);
        check("rst_changed", changed, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        reset = 1'b0;
        tick(3);

        // Bank 3 FF->FE: accepted exactly at S+6
        raw[3] = 8'hFE;
        tick(6);
        check("b3_early", sw[3], 8'hFF);
        check("b3_early_chg", changed, 8'h00);
        tick(1);
        check("b3_accept", sw[3], 8'hFE);
        check("b3_changed", changed, 8'h08);
        check("b3_irq", {7'd0, irq}, 8'h01);
        check("b3_other0", sw[0], 8'hFF);
        check("b3_other7", sw[7], 8'hFF);

        // Bank 0 short glitch aborts
        raw[0] = 8'h7F;
        tick(3);
        raw[0] = 8'hFF;
        tick(10);
        check("b0_glitch", sw[0], 8'hFF);
        check("b0_glitch_chg", changed, 8'h08);

        // Bank 0 alternating 7F/3F never settles, then 3F holds
        raw[0] = 8'h7F; tick(2);
        raw[0] = 8'h3F; tick(2);
        raw[0] = 8'h7F; tick(2);
        raw[0] = 8'h3F; tick(2);
        raw[0] = 8'h7F; tick(2);
        check("b0_alt", sw[0], 8'hFF);
        raw[0] = 8'h3F;
        tick(6);
        check("b0_hold_early", sw[0], 8'hFF);
        tick(1);
        check("b0_hold_accept", sw[0], 8'h3F);
        check("b0_changed", changed, 8'h09);

        // Clear on the same cycle as a bank 3 accept: set wins
        raw[3] = 8'hFC;
        tick(6);
        check("b3_pre_clr", sw[3], 8'hFE);
        clr_changed = 8'h08;
        tick(1);
        clr_changed = 8'h00;
        check("b3_fc", sw[3], 8'hFC);
        check("set_wins", changed, 8'h09);
        clr_changed = 8'h08;
        tick(1);
        clr_changed = 8'h00;
        check("clr3", changed, 8'h01);
        check("clr3_irq", {7'd0, irq}, 8'h01);
        clr_changed = 8'h01;
        tick(1);
        clr_changed = 8'h00;
        check("clr0", changed, 8'h00);
        check("clr0_irq", {7'd0, irq}, 8'h00);
        clr_changed = 8'h10;
        tick(1);
        clr_changed = 8'h00;
        check("clr_idle", changed, 8'h00);

        // All banks to 00 on the same edge
        for (int i = 0; i < 8; i++) raw[i] = 8'h00;
        tick(6);
        check("all_early5", sw[5], 8'hFF);
        tick(1);
        check_all_sw("all00", 8'h00);
        check("all_changed", changed, 8'hFF);
        check("all_irq", {7'd0, irq}, 8'h01);

        // Return to FF, then asynchronous reset mid-count between edges
        for (int i = 0; i < 8; i++) raw[i] = 8'hFF;
        tick(4);
        check("mid_count", sw[2], 8'h00);
        #3;
        reset = 1'b1;
        #1;
        check_all_sw("async_rst", 8'hFF);
        check("async_rst_chg", changed, 8'h00);
        check("async_rst_irq", {7'd0, irq}, 8'h00);
        tick(1);
        reset = 1'b0;
        tick(10);
        check_all_sw("post_rst", 8'hFF);
        check("post_rst_chg", changed, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_dip_switch_debouncer
`default_nettype wire
